rr_arb_mux: RTL

//   Parametrised N-channel, W-bit data selector with a registered output stage.

---
 rtl/rr_arb_mux.sv | 75 +++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready merge: an internal round-robin or fixed-priority arbiter
// picks one requester per cycle into a single registered output slot.
module rr_arb_mux #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  parameter  int MODE     = 0,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  // Handshake: a word moves on any edge where valid && ready are both high,
  // on the input side (per channel) and on the output side alike.

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] gnt;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_data;
  logic             load, xfer;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  int               idx;

  // Scan starting at the pointer (or at 0 in fixed priority), wrapping modulo CHANNELS.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_data  = '0;
    idx       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (MODE == 1) ? k : int'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_found && in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = SEL_W'(idx);
        gnt_data  = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign xfer     = rst_n && load && gnt_found;
  assign in_ready = xfer ? (CHANNELS'(1) << gnt) : '0;
  assign ptr_d    = (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
      out_sel_q   <= gnt;
      if (MODE == 0) ptr_q <= ptr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
